pong_game_fsm: RTL and testbench

//  Game supervisor for VGA pong; consumes the ball position published by the ball controller.

---
 rtl/pong_game_fsm_pkg.sv | 34 +++
 rtl/pong_game_fsm_if.sv | 39 +++
 rtl/pong_game_fsm_paddle_hit.sv | 31 +++
 rtl/pong_game_fsm.sv | 143 ++++++++++++++
 tb/tb_pong_game_fsm.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/pong_game_fsm_pkg.sv
// ---------------------------------------------------------------------------
// pong_game_fsm_pkg
//   Shared pong constants and types: playfield size in grid cells, paddle
//   length, match score limit, coordinate/score widths and the supervisor
//   FSM state type. The ball controller, paddle control and renderer use
//   the same values, so they live in one place.
// ---------------------------------------------------------------------------
package pong_game_fsm_pkg;

  localparam int unsigned GAME_WIDTH    = 40;  // grid columns
  localparam int unsigned GAME_HEIGHT   = 30;  // grid rows
  localparam int unsigned PADDLE_HEIGHT = 6;   // paddle length in rows
  localparam int unsigned SCORE_LIMIT   = 9;   // points that win a match

  localparam int unsigned COORD_W = 6;         // grid coordinate width
  localparam int unsigned SCORE_W = 4;         // score width (limit <= 15)

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RUNNING   = 3'd1,
    ST_POINT     = 3'd2,
    ST_CLEANUP   = 3'd3,
    ST_GAME_OVER = 3'd4
  } state_t;

  // Saturating score increment: never moves past the limit.
  function automatic logic [SCORE_W-1:0] score_inc(
    input logic [SCORE_W-1:0] score,
    input logic [SCORE_W-1:0] limit
  );
    return (score >= limit) ? score : score + 1'b1;
  endfunction

endpackage

// File: rtl/pong_game_fsm_if.sv
// ---------------------------------------------------------------------------
// pong_game_fsm_if
//   Signal bundle between the pong game supervisor and its neighbours.
//   Inputs (i_*): debounced start button, ball position from the ball
//   controller, paddle top rows. Outputs (o_*): rally enable for the ball
//   controller, scores, one-cycle point pulses, match-over flag and winner.
//   slave  : the supervisor (consumes i_*, drives o_*)
//   master : the surrounding system / testbench (drives i_*, consumes o_*)
// ---------------------------------------------------------------------------
interface pong_game_fsm_if;
  import pong_game_fsm_pkg::*;

  logic               i_start;
  logic [COORD_W-1:0] i_ball_x;
  logic [COORD_W-1:0] i_ball_y;
  logic [COORD_W-1:0] i_paddle_p1_y;
  logic [COORD_W-1:0] i_paddle_p2_y;

  logic               o_game_active;
  logic [SCORE_W-1:0] o_p1_score;
  logic [SCORE_W-1:0] o_p2_score;
  logic               o_point_p1;
  logic               o_point_p2;
  logic               o_game_over;
  logic               o_winner;

  modport slave (
    input  i_start, i_ball_x, i_ball_y, i_paddle_p1_y, i_paddle_p2_y,
    output o_game_active, o_p1_score, o_p2_score,
           o_point_p1, o_point_p2, o_game_over, o_winner
  );

  modport master (
    output i_start, i_ball_x, i_ball_y, i_paddle_p1_y, i_paddle_p2_y,
    input  o_game_active, o_p1_score, o_p2_score,
           o_point_p1, o_point_p2, o_game_over, o_winner
  );

endinterface

// File: rtl/pong_game_fsm_paddle_hit.sv
// ---------------------------------------------------------------------------
// pong_paddle_hit
//   Combinational test of whether the ball row lies within a paddle span.
//   ball_y_i   : ball row
//   paddle_y_i : paddle top row
//   hit_o      : 1 when paddle_y_i <= ball_y_i < paddle_y_i + PADDLE_HEIGHT
// ---------------------------------------------------------------------------
module pong_paddle_hit
  import pong_game_fsm_pkg::*;
#(
  parameter int unsigned PADDLE_HEIGHT_P = PADDLE_HEIGHT
) (
  input  logic [COORD_W-1:0] ball_y_i,
  input  logic [COORD_W-1:0] paddle_y_i,
  output logic               hit_o
);

  // One extra bit so a paddle near the bottom of the 6-bit range cannot
  // wrap its lower edge around to row 0.
  logic [COORD_W:0] ball_w;
  logic [COORD_W:0] top_w;
  logic [COORD_W:0] end_w;

  always_comb begin
    ball_w = {1'b0, ball_y_i};
    top_w  = {1'b0, paddle_y_i};
    end_w  = top_w + (COORD_W + 1)'(PADDLE_HEIGHT_P);
    hit_o  = (ball_w >= top_w) && (ball_w < end_w);
  end

endmodule

// File: rtl/pong_game_fsm.sv
// ---------------------------------------------------------------------------
// pong_game_fsm
//   Game supervisor for VGA pong on the 25 MHz pixel clock. Starts rallies on
//   a rising edge of the start button, detects paddle misses at the goal
//   columns, keeps both scores, and ends the match at the score limit.
//   i_clk : pixel clock
//   i_rst : synchronous, active-high reset
//   bus   : pong_game_fsm_if.slave (start, ball/paddle positions in;
//           rally enable, scores, point pulses, game over, winner out)
//   All outputs are registered.
// ---------------------------------------------------------------------------
module pong_game_fsm
  import pong_game_fsm_pkg::*;
#(
  parameter int unsigned c_game_width    = GAME_WIDTH,
  parameter int unsigned c_game_height   = GAME_HEIGHT,
  parameter int unsigned c_paddle_height = PADDLE_HEIGHT,
  parameter int unsigned c_score_limit   = SCORE_LIMIT
) (
  input  logic           i_clk,
  input  logic           i_rst,
  pong_game_fsm_if.slave bus
);

  localparam logic [COORD_W-1:0] GOAL_P1   = '0;
  localparam logic [COORD_W-1:0] GOAL_P2   = COORD_W'(c_game_width - 1);
  localparam logic [COORD_W-1:0] CENTRE_X  = COORD_W'(c_game_width / 2);
  localparam logic [COORD_W-1:0] CENTRE_Y  = COORD_W'(c_game_height / 2);
  localparam logic [SCORE_W-1:0] SCORE_MAX = SCORE_W'(c_score_limit);

  state_t             state_q, state_d;
  logic               start_q;
  logic [SCORE_W-1:0] p1_score_q, p1_score_d;
  logic [SCORE_W-1:0] p2_score_q, p2_score_d;
  logic               active_q, active_d;
  logic               point_p1_q, point_p1_d;
  logic               point_p2_q, point_p2_d;
  logic               game_over_q, game_over_d;
  logic               winner_q, winner_d;

  logic start_rise;
  logic p1_hit, p2_hit;
  logic p1_miss, p2_miss;
  logic ball_centred;
  logic limit_reached;

  pong_paddle_hit #(.PADDLE_HEIGHT_P(c_paddle_height)) u_hit_p1 (
    .ball_y_i   (bus.i_ball_y),
    .paddle_y_i (bus.i_paddle_p1_y),
    .hit_o      (p1_hit)
  );

  pong_paddle_hit #(.PADDLE_HEIGHT_P(c_paddle_height)) u_hit_p2 (
    .ball_y_i   (bus.i_ball_y),
    .paddle_y_i (bus.i_paddle_p2_y),
    .hit_o      (p2_hit)
  );

  always_comb begin
    start_rise    = bus.i_start & ~start_q;
    p1_miss       = (bus.i_ball_x == GOAL_P1) && !p1_hit;
    p2_miss       = (bus.i_ball_x == GOAL_P2) && !p2_hit;
    ball_centred  = (bus.i_ball_x == CENTRE_X) && (bus.i_ball_y == CENTRE_Y);
    limit_reached = (p1_score_q == SCORE_MAX) || (p2_score_q == SCORE_MAX);
  end

  // State register plus registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      start_q     <= bus.i_start;  // a button held through reset is not an edge
      p1_score_q  <= '0;
      p2_score_q  <= '0;
      active_q    <= 1'b0;
      point_p1_q  <= 1'b0;
      point_p2_q  <= 1'b0;
      game_over_q <= 1'b0;
      winner_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= bus.i_start;
      p1_score_q  <= p1_score_d;
      p2_score_q  <= p2_score_d;
      active_q    <= active_d;
      point_p1_q  <= point_p1_d;
      point_p2_q  <= point_p2_d;
      game_over_q <= game_over_d;
      winner_q    <= winner_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:      if (start_rise) state_d = ST_RUNNING;
      ST_RUNNING:   if (p1_miss || p2_miss) state_d = ST_POINT;
      ST_POINT:     state_d = limit_reached ? ST_GAME_OVER : ST_CLEANUP;
      // Wait for the ball controller to recentre so a stale goal position
      // cannot score again on the next start.
      ST_CLEANUP:   if (ball_centred) state_d = ST_IDLE;
      ST_GAME_OVER: if (start_rise) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Output logic: next values for the registered outputs. Flags follow the
  // state being entered so they change on the same edge as the state.
  always_comb begin
    p1_score_d = p1_score_q;
    p2_score_d = p2_score_q;
    point_p1_d = 1'b0;
    point_p2_d = 1'b0;

    if (state_q == ST_RUNNING) begin
      if (p1_miss) begin
        p2_score_d = score_inc(p2_score_q, SCORE_MAX);
        point_p2_d = 1'b1;
      end else if (p2_miss) begin
        p1_score_d = score_inc(p1_score_q, SCORE_MAX);
        point_p1_d = 1'b1;
      end
    end

    if (state_q == ST_GAME_OVER && start_rise) begin
      p1_score_d = '0;
      p2_score_d = '0;
    end

    active_d    = (state_d == ST_RUNNING);
    game_over_d = (state_d == ST_GAME_OVER);
    winner_d    = (state_d == ST_GAME_OVER) && (p2_score_d == SCORE_MAX);
  end

  assign bus.o_game_active = active_q;
  assign bus.o_p1_score    = p1_score_q;
  assign bus.o_p2_score    = p2_score_q;
  assign bus.o_point_p1    = point_p1_q;
  assign bus.o_point_p2    = point_p2_q;
  assign bus.o_game_over   = game_over_q;
  assign bus.o_winner      = winner_q;

endmodule

// File: tb/tb_pong_game_fsm.sv
// ---------------------------------------------------------------------------
// tb_pong_game_fsm
//   Directed bench for pong_game_fsm: start-edge detection, paddle hit/miss
//   at both goals (including a paddle near the top of the 6-bit range),
//   recentre wait, match end at 9 points, and reset mid-rally.
// ---------------------------------------------------------------------------
module tb_pong_game_fsm;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned exp_p1   = 0;
  int unsigned exp_p2   = 0;

  pong_game_fsm_if bif ();

  pong_game_fsm #(
    .c_game_width    (40),
    .c_game_height   (30),
    .c_paddle_height (6),
    .c_score_limit   (9)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_ball(input int unsigned x, input int unsigned y);
    bif.i_ball_x = 6'(x);
    bif.i_ball_y = 6'(y);
  endtask

  task automatic chk_scores(input string tag);
    chk({tag, "_p1"}, 8'(bif.o_p1_score), 8'(exp_p1));
    chk({tag, "_p2"}, 8'(bif.o_p2_score), 8'(exp_p2));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_active"}, 8'(bif.o_game_active), 8'd0);
    chk({tag, "_p1"},     8'(bif.o_p1_score),    8'd0);
    chk({tag, "_p2"},     8'(bif.o_p2_score),    8'd0);
    chk({tag, "_pt1"},    8'(bif.o_point_p1),    8'd0);
    chk({tag, "_pt2"},    8'(bif.o_point_p2),    8'd0);
    chk({tag, "_over"},   8'(bif.o_game_over),   8'd0);
    chk({tag, "_winner"}, 8'(bif.o_winner),      8'd0);
  endtask

  // One full rally from IDLE: start edge, a miss at one goal with both
  // paddles at row 0 (ball row 20 is outside the span), then recentre.
  task automatic rally(input bit p1_misses);
    bif.i_start       = 1'b1;
    bif.i_paddle_p1_y = 6'd0;
    bif.i_paddle_p2_y = 6'd0;
    set_ball(20, 15);
    step();
    chk("rally_start", 8'(bif.o_game_active), 8'd1);
    bif.i_start = 1'b0;
    if (p1_misses) set_ball(0, 20);
    else           set_ball(39, 20);
    step();
    if (p1_misses) begin
      if (exp_p2 < 9) exp_p2++;
      chk("rally_pt2", 8'(bif.o_point_p2), 8'd1);
      chk("rally_pt1", 8'(bif.o_point_p1), 8'd0);
    end else begin
      if (exp_p1 < 9) exp_p1++;
      chk("rally_pt1", 8'(bif.o_point_p1), 8'd1);
      chk("rally_pt2", 8'(bif.o_point_p2), 8'd0);
    end
    chk("rally_stop", 8'(bif.o_game_active), 8'd0);
    chk_scores("rally");
    set_ball(20, 15);
    step();
    step();
  endtask

  initial begin
    int unsigned rises;
    logic        prev;

    bif.i_start       = 1'b0;
    bif.i_paddle_p1_y = 6'd8;
    bif.i_paddle_p2_y = 6'd8;
    set_ball(20, 15);

    // Reset state
    step();
    step();
    rst = 1'b0;
    chk_all_zero("reset");

    // 1: held start gives exactly one rally start
    bif.i_start = 1'b1;
    step();
    chk("t1_active_rise", 8'(bif.o_game_active), 8'd1);
    rises = 1;
    prev  = 1'b1;
    for (int i = 0; i < 99; i++) begin
      step();
      if (bif.o_game_active && !prev) rises++;
      prev = bif.o_game_active;
    end
    chk("t1_rises", 8'(rises), 8'd1);
    chk("t1_active_held", 8'(bif.o_game_active), 8'd1);
    bif.i_start = 1'b0;

    // 2: hit at P1 goal, then a miss
    set_ball(0, 10);
    step();
    chk("t2_hit_pt2", 8'(bif.o_point_p2), 8'd0);
    chk("t2_hit_active", 8'(bif.o_game_active), 8'd1);
    chk_scores("t2_hit");
    set_ball(0, 14);
    step();
    exp_p2 = 1;
    chk("t2_miss_pt2", 8'(bif.o_point_p2), 8'd1);
    chk("t2_miss_pt1", 8'(bif.o_point_p1), 8'd0);
    chk("t2_miss_active", 8'(bif.o_game_active), 8'd0);
    chk_scores("t2_miss");
    step();
    chk("t2_pulse_end", 8'(bif.o_point_p2), 8'd0);
    chk("t2_no_over", 8'(bif.o_game_over), 8'd0);

    // 4: stale goal position holds CLEANUP; start edges ignored there
    for (int i = 0; i < 5; i++) begin
      bif.i_start = (i == 1);
      step();
    end
    bif.i_start = 1'b0;
    chk("t4_hold_active", 8'(bif.o_game_active), 8'd0);
    chk("t4_hold_pt2", 8'(bif.o_point_p2), 8'd0);
    chk_scores("t4_hold");
    set_ball(20, 15);
    step();
    bif.i_start = 1'b1;
    step();
    chk("t4_idle_restart", 8'(bif.o_game_active), 8'd1);
    bif.i_start = 1'b0;

    // 3: P2 paddle at row 60; row 62 is inside its span, row 2 is not
    bif.i_paddle_p2_y = 6'd60;
    set_ball(39, 62);
    step();
    chk("t3_wrap_hit_pt1", 8'(bif.o_point_p1), 8'd0);
    chk("t3_wrap_hit_active", 8'(bif.o_game_active), 8'd1);
    set_ball(39, 2);
    step();
    exp_p1 = 1;
    chk("t3_miss_pt1", 8'(bif.o_point_p1), 8'd1);
    chk("t3_miss_active", 8'(bif.o_game_active), 8'd0);
    chk_scores("t3_miss");
    set_ball(20, 15);
    step();
    step();

    // 5: P2 reaches the limit
    for (int i = 0; i < 8; i++) rally(1'b1);
    chk("t5_over", 8'(bif.o_game_over), 8'd1);
    chk("t5_winner", 8'(bif.o_winner), 8'd1);
    chk("t5_active", 8'(bif.o_game_active), 8'd0);
    chk_scores("t5_final");
    set_ball(0, 20);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t5_frozen_pt2", 8'(bif.o_point_p2), 8'd0);
    end
    chk_scores("t5_frozen");
    chk("t5_still_over", 8'(bif.o_game_over), 8'd1);
    set_ball(20, 15);
    bif.i_start = 1'b1;
    step();
    bif.i_start = 1'b0;
    exp_p1 = 0;
    exp_p2 = 0;
    chk_scores("t5_clear");
    chk("t5_clear_over", 8'(bif.o_game_over), 8'd0);
    chk("t5_clear_winner", 8'(bif.o_winner), 8'd0);
    chk("t5_clear_active", 8'(bif.o_game_active), 8'd0);
    step();

    // 6: reset mid-rally at 3:5
    for (int i = 0; i < 3; i++) rally(1'b0);
    for (int i = 0; i < 5; i++) rally(1'b1);
    chk("t6_pre_p1", 8'(bif.o_p1_score), 8'd3);
    chk("t6_pre_p2", 8'(bif.o_p2_score), 8'd5);
    bif.i_start = 1'b1;
    step();
    chk("t6_rally_on", 8'(bif.o_game_active), 8'd1);
    rst = 1'b1;
    step();
    chk_all_zero("t6_reset");
    rst = 1'b0;
    step();
    chk("t6_held_start", 8'(bif.o_game_active), 8'd0);
    bif.i_start = 1'b0;
    step();
    bif.i_start = 1'b1;
    step();
    chk("t6_idle_restart", 8'(bif.o_game_active), 8'd1);
    bif.i_start = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
